// File: rtl/iob_reset_sequencer.sv
// iob_reset_sequencer: staggered multi-channel reset release gated on synchronised ready inputs; IOB_RESET_SEQ_WATCHDOG_EN adds a WAIT_READY timeout with retry
module iob_reset_sequencer #(
  parameter int N_CH        = 3,
  parameter int N_READY     = 2,
  parameter int START       = 5,
  parameter int DURATION    = 10,
  parameter int STAGE_DELAY = 4,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               cke_i,
  input  logic               start_i,
  input  logic [N_READY-1:0] ready_i,
  output logic [N_CH-1:0]    rst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o
);
  typedef enum logic [2:0] {DELAY, ASSERT, WAIT_READY, RELEASE, DONE} state_t;
  localparam logic [CNT_W-1:0] START_C = CNT_W'(START);
  localparam logic [CNT_W-1:0] DUR_C   = CNT_W'(DURATION);
  localparam logic [CNT_W-1:0] STG_C   = CNT_W'(STAGE_DELAY);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [N_CH-1:0] rst_nx;
  logic [N_READY-1:0] sync1, sync2;
  logic rdy_all, to_set;
  assign cnt_inc = cnt + 1'b1;
  assign rdy_all = &sync2;
  assign busy_o  = ~done_o;
  // next state: restart and ready loss both funnel into ASSERT; releases shift a zero in from channel 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_inc;
    rst_nx   = rst_o;
    to_set   = 1'b0;
    if (start_i || (!rdy_all && (state == RELEASE || state == DONE))) begin
      state_nx = ASSERT;
      cnt_nx   = '0;
      rst_nx   = '1;
    end else begin
      case (state)
        DELAY: begin
          state_nx = (cnt_inc >= START_C) ? ASSERT : DELAY;
          cnt_nx   = (cnt_inc >= START_C) ? '0 : cnt_inc;
        end
        ASSERT: begin
          state_nx = (cnt_inc >= DUR_C) ? WAIT_READY : ASSERT;
          cnt_nx   = (cnt_inc >= DUR_C) ? '0 : cnt_inc;
        end
        WAIT_READY: begin
          if (rdy_all) begin
            rst_nx   = rst_o << 1;
            state_nx = (rst_nx == '0) ? DONE : RELEASE;
            cnt_nx   = '0;
          end else begin
`ifdef IOB_RESET_SEQ_WATCHDOG_EN
            to_set   = (cnt_inc >= CNT_W'(TIMEOUT));
            state_nx = to_set ? ASSERT : WAIT_READY;
            cnt_nx   = to_set ? '0 : cnt_inc;
`else
            cnt_nx   = cnt;
`endif
          end
        end
        RELEASE: begin
          if (cnt_inc >= STG_C) begin
            rst_nx   = rst_o << 1;
            state_nx = (rst_nx == '0) ? DONE : RELEASE;
            cnt_nx   = '0;
          end
        end
        DONE: begin
          cnt_nx = cnt;
          rst_nx = '0;
        end
        default: ;
      endcase
    end
  end
  // state, counter, registered outputs and ready synchroniser, all frozen while cke_i is low
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state  <= DELAY;
      cnt    <= '0;
      rst_o  <= '1;
      done_o <= 1'b0;
      sync1  <= '0;
      sync2  <= '0;
    end else if (cke_i) begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rst_o  <= rst_nx;
      done_o <= (state_nx == DONE);
      sync1  <= ready_i;
      sync2  <= sync1;
    end
  end
`ifdef IOB_RESET_SEQ_WATCHDOG_EN
  // sticky timeout flag, cleared only by arst_i
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) timeout_o <= 1'b0;
    else if (cke_i && to_set) timeout_o <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0) | to_set;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_iob_reset_sequencer.sv
// tb_iob_reset_sequencer: directed checks of power-up release, ready stall/loss, restart, clock enable and async reset
module tb_iob_reset_sequencer;
  logic clk = 1'b0;
  logic arst, cke, start;
  logic [1:0] ready;
  logic [2:0] rst;
  logic busy, done, tmo;
  int total = 0;
  int bad = 0;
  iob_reset_sequencer #(.TIMEOUT(100)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .start_i(start), .ready_i(ready),
    .rst_o(rst), .busy_o(busy), .done_o(done), .timeout_o(tmo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    arst = 1'b1; cke = 1'b1; start = 1'b0; ready = 2'b11;
    cyc(2);
    check("reset_rst", 32'(rst), 7);
    check("reset_busy", 32'(busy), 1);
    check("reset_done", 32'(done), 0);
    check("reset_tmo", 32'(tmo), 0);
    arst = 1'b0;
    cyc(15); check("pu_hold", 32'(rst), 7);
    cyc(1);  check("pu_rel0", 32'(rst), 6);
    cyc(3);  check("pu_rel0_keep", 32'(rst), 6);
    cyc(1);  check("pu_rel1", 32'(rst), 4);
    cyc(3);  check("pu_rel1_keep", 32'(rst), 4);
    check("pu_not_done", 32'(done), 0);
    cyc(1);  check("pu_rel2", 32'(rst), 0);
    check("pu_done", 32'(done), 1);
    check("pu_busy", 32'(busy), 0);
    pulse_start();
    check("rs_rst", 32'(rst), 7);
    check("rs_busy", 32'(busy), 1);
    check("rs_done", 32'(done), 0);
    cyc(10); check("rs_hold", 32'(rst), 7);
    cyc(1);  check("rs_rel0", 32'(rst), 6);
    ready = 2'b01;
    cyc(2);  check("loss_lat", 32'(rst), 6);
    cyc(1);  check("loss_rst", 32'(rst), 7);
    cyc(30); check("stall_rst", 32'(rst), 7);
    check("stall_busy", 32'(busy), 1);
    ready = 2'b11;
    cyc(2);  check("rdy_lat", 32'(rst), 7);
    cyc(1);  check("rdy_rel0", 32'(rst), 6);
    cyc(4);  check("rdy_rel1", 32'(rst), 4);
    cyc(4);  check("rdy_rel2", 32'(rst), 0);
    check("rdy_done", 32'(done), 1);
    pulse_start();
    cyc(4);
    cke = 1'b0;
    cyc(20); check("cke_frz", 32'(rst), 7);
    check("cke_frz_busy", 32'(busy), 1);
    cke = 1'b1;
    cyc(6);  check("cke_hold", 32'(rst), 7);
    cyc(1);  check("cke_rel0", 32'(rst), 6);
    #2 arst = 1'b1;
    #1;
    check("arst_rst", 32'(rst), 7);
    check("arst_done", 32'(done), 0);
    check("arst_busy", 32'(busy), 1);
    @(negedge clk);
    arst = 1'b0;
    cyc(2);
    pulse_start();
    cyc(4);
    pulse_start();
    cyc(9);  check("ext_hold", 32'(rst), 7);
    cyc(1);  check("ext_wait", 32'(rst), 7);
    cyc(1);  check("ext_rel0", 32'(rst), 6);
    check("no_tmo", 32'(tmo), 0);
`ifdef IOB_RESET_SEQ_WATCHDOG_EN
    arst = 1'b1; ready = 2'b00;
    cyc(1);
    arst = 1'b0;
    cyc(114); check("wd_pre", 32'(tmo), 0);
    cyc(1);   check("wd_set", 32'(tmo), 1);
    check("wd_rst", 32'(rst), 7);
    ready = 2'b11;
    cyc(11);  check("wd_rel0", 32'(rst), 6);
    check("wd_sticky", 32'(tmo), 1);
    #2 arst = 1'b1;
    #1;
    check("wd_arst_rst", 32'(rst), 7);
    check("wd_arst_tmo", 32'(tmo), 0);
    @(negedge clk);
    arst = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
